pe_stream_ctrl: RTL and testbench

Sequencer for a single attention-datapath PE. On start, it reads LEN activation/weight pairs from two synchronous read-port SRAMs and streams them into the PE, one pair per cycle. It then drives one zero cycle with input_done, waits for calc_done and latches the PE sum as the result. It sits between the operand SRAMs and the pe instance and replaces the hand-written stimulus sequencing used in PE benches.

---
 rtl/pe_stream_ctrl_pkg.sv | 18 +
 rtl/pe_stream_ctrl_wait_timer.sv | 36 +++
 rtl/pe_stream_ctrl.sv | 142 ++++++++++++++
 tb/tb_pe_stream_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_stream_ctrl_pkg.sv
// Shared types and default widths for the PE stream sequencer.
package pe_stream_ctrl_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ACC_W_DEF   = 36;
    localparam int ADDR_W_DEF  = 2;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STREAM = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

endpackage

// File: rtl/pe_stream_ctrl_wait_timer.sv
// WAIT-state timeout counter: held at zero while idle, counts up while
// running, flags the terminal count TIMEOUT-1.
module pe_wait_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    output logic tc_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload to zero whenever not running so every WAIT starts fresh.
    always_comb begin
        cnt_d = '0;
        if (run_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = run_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/pe_stream_ctrl.sv
// Sequencer feeding one PE from the activation/weight SRAMs.
//
//   state  | meaning
//   IDLE   | waiting for start
//   STREAM | issuing one read per cycle to both SRAMs
//   DRAIN  | last read data presented to the PE
//   FLUSH  | zero operands, input_done to the PE
//   WAIT   | waiting for calc_done, bounded by the timeout
//   DONE   | one-cycle done pulse
module pe_stream_ctrl
    import pe_stream_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ACC_W   = ACC_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ACC_W-1:0]  result_o,
    output logic              act_rd_en_o,
    output logic [ADDR_W-1:0] act_addr_o,
    input  logic [DATA_W-1:0] act_rd_data_i,
    output logic              wgt_rd_en_o,
    output logic [ADDR_W-1:0] wgt_addr_o,
    input  logic [DATA_W-1:0] wgt_rd_data_i,
    output logic              pe_en_o,
    output logic [DATA_W-1:0] pe_active_o,
    output logic [DATA_W-1:0] pe_weight_o,
    output logic              pe_input_done_o,
    input  logic [ACC_W-1:0]  pe_sum_i,
    input  logic              pe_calc_done_i
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ACC_W-1:0]  result_q, result_d;
    logic              err_q, err_d;
    logic              vld_q;
    logic              rd_en;
    logic              tc;
    logic [ADDR_W:0]   len_clamped;

    assign len_clamped = (len_i > LEN_MAX) ? LEN_MAX : len_i;

    pe_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run_i (state_q == ST_WAIT),
        .tc_o  (tc)
    );

    // Next-state, captured length, read index, result and error flag.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i == '0) begin
                        result_d = '0;
                        state_d  = ST_DONE;
                    end else begin
                        len_d   = len_clamped;
                        idx_d   = '0;
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                idx_d = idx_q + ADDR_W'(1);
                if ({1'b0, idx_q} == len_q - LEN_ONE) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_WAIT;
            ST_WAIT: begin
                // calc_done wins over a coincident timeout.
                if (pe_calc_done_i) begin
                    result_d = pe_sum_i;
                    state_d  = ST_DONE;
                end else if (tc) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
            vld_q    <= rd_en;
        end
    end

    assign rd_en           = (state_q == ST_STREAM);
    assign act_rd_en_o     = rd_en;
    assign wgt_rd_en_o     = rd_en;
    assign act_addr_o      = rd_en ? idx_q : '0;
    assign wgt_addr_o      = rd_en ? idx_q : '0;
    assign busy_o          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign pe_en_o         = busy_o;
    assign done_o          = (state_q == ST_DONE);
    assign err_o           = err_q;
    assign result_o        = result_q;
    assign pe_input_done_o = (state_q == ST_FLUSH);
    // SRAM data arrives one cycle after the read; pass it straight through.
    assign pe_active_o     = vld_q ? act_rd_data_i : '0;
    assign pe_weight_o     = vld_q ? wgt_rd_data_i : '0;

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Bench for pe_stream_ctrl with behavioural SRAMs and a behavioural PE.
module tb_pe_stream_ctrl;

    localparam int DATA_W  = 16;
    localparam int ACC_W   = 36;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 8;
    localparam int DEPTH   = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W:0]   len_i = '0;
    logic              busy_o, done_o, err_o;
    logic [ACC_W-1:0]  result_o;
    logic              act_rd_en_o, wgt_rd_en_o;
    logic [ADDR_W-1:0] act_addr_o, wgt_addr_o;
    logic [DATA_W-1:0] act_rd_data, wgt_rd_data;
    logic              pe_en_o, pe_input_done_o;
    logic [DATA_W-1:0] pe_active_o, pe_weight_o;
    logic [ACC_W-1:0]  pe_sum;
    logic              pe_cd;
    logic              pe_calc_done;

    int checks = 0;
    int failures = 0;

    logic [DATA_W-1:0] act_mem [DEPTH];
    logic [DATA_W-1:0] wgt_mem [DEPTH];
    int                pe_lat = 2;
    bit                pe_stuck = 1'b0;
    bit                inject_cd = 1'b0;
    logic [ACC_W-1:0]  last_result = '0;

    always #5 clk = ~clk;

    pe_stream_ctrl #(
        .DATA_W  (DATA_W),
        .ACC_W   (ACC_W),
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .result_o        (result_o),
        .act_rd_en_o     (act_rd_en_o),
        .act_addr_o      (act_addr_o),
        .act_rd_data_i   (act_rd_data),
        .wgt_rd_en_o     (wgt_rd_en_o),
        .wgt_addr_o      (wgt_addr_o),
        .wgt_rd_data_i   (wgt_rd_data),
        .pe_en_o         (pe_en_o),
        .pe_active_o     (pe_active_o),
        .pe_weight_o     (pe_weight_o),
        .pe_input_done_o (pe_input_done_o),
        .pe_sum_i        (pe_sum),
        .pe_calc_done_i  (pe_calc_done)
    );

    assign pe_calc_done = pe_cd | inject_cd;

    // Synchronous-read SRAMs, one cycle latency.
    always @(posedge clk) begin
        if (act_rd_en_o) act_rd_data <= act_mem[act_addr_o];
        if (wgt_rd_en_o) wgt_rd_data <= wgt_mem[wgt_addr_o];
    end

    // Behavioural PE: accumulate while enabled, report pe_lat cycles after input_done.
    logic [ACC_W-1:0] pe_acc, pe_pend;
    int               pe_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_acc <= '0; pe_pend <= '0; pe_sum <= '0; pe_cd <= 1'b0; pe_cnt <= 0;
        end else begin
            pe_cd <= 1'b0;
            if (pe_input_done_o) begin
                pe_pend <= pe_acc;
                pe_acc  <= '0;
                pe_cnt  <= pe_lat;
            end else if (pe_en_o) begin
                pe_acc <= pe_acc + ACC_W'(pe_active_o) * ACC_W'(pe_weight_o);
            end
            if (pe_cnt != 0) begin
                pe_cnt <= pe_cnt - 1;
                if (pe_cnt == 1 && !pe_stuck) begin
                    pe_cd  <= 1'b1;
                    pe_sum <= pe_pend;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_busy"}, 64'(busy_o), 64'd0);
        check({p, "_done"}, 64'(done_o), 64'd0);
        check({p, "_err"}, 64'(err_o), 64'd0);
        check({p, "_act_rd_en"}, 64'(act_rd_en_o), 64'd0);
        check({p, "_wgt_rd_en"}, 64'(wgt_rd_en_o), 64'd0);
        check({p, "_act_addr"}, 64'(act_addr_o), 64'd0);
        check({p, "_wgt_addr"}, 64'(wgt_addr_o), 64'd0);
        check({p, "_pe_en"}, 64'(pe_en_o), 64'd0);
        check({p, "_input_done"}, 64'(pe_input_done_o), 64'd0);
        check({p, "_result"}, 64'(result_o), 64'd0);
        check({p, "_pe_active"}, 64'(pe_active_o), 64'd0);
        check({p, "_pe_weight"}, 64'(pe_weight_o), 64'd0);
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) begin
            act_mem[i] = DATA_W'($urandom);
            wgt_mem[i] = DATA_W'($urandom);
        end
    endtask

    // Called at a negedge; starts a run there and ends at the negedge after done.
    task automatic run_op(input int n, input bit stuck, input bit spam, input bit inject);
        int m, t, exp_done_t;
        bit got;
        logic [ACC_W-1:0] exp_res;
        bit exp_err;
        m = (n > DEPTH) ? DEPTH : n;
        exp_res = '0;
        for (int i = 0; i < m; i++) exp_res += ACC_W'(act_mem[i]) * ACC_W'(wgt_mem[i]);
        exp_err = stuck && (m > 0);
        if (exp_err) exp_res = last_result;
        if (m == 0) exp_done_t = 1;
        else if (stuck) exp_done_t = m + 3 + TIMEOUT;
        else exp_done_t = m + 4 + pe_lat;
        pe_stuck = stuck;
        start_i = 1'b1;
        len_i = (ADDR_W+1)'(n);
        @(posedge clk);
        t = 0;
        got = 1'b0;
        while (!got && t < 200) begin
            @(negedge clk);
            t++;
            start_i = spam;
            if (spam) len_i = (ADDR_W+1)'($urandom_range(0, 7));
            inject_cd = inject && (m > 0) && (t == 1);
            if (t == 1) check("err_cleared_on_start", 64'(err_o), 64'd0);
            check("act_rd_en", 64'(act_rd_en_o), 64'(m > 0 && t <= m));
            check("wgt_rd_en", 64'(wgt_rd_en_o), 64'(m > 0 && t <= m));
            if (m > 0 && t <= m) begin
                check("act_addr", 64'(act_addr_o), 64'(t - 1));
                check("wgt_addr", 64'(wgt_addr_o), 64'(t - 1));
            end
            if (m > 0 && t >= 2 && t <= m + 1) begin
                check("pe_active", 64'(pe_active_o), 64'(act_mem[t-2]));
                check("pe_weight", 64'(pe_weight_o), 64'(wgt_mem[t-2]));
            end else begin
                check("pe_active_zero", 64'(pe_active_o), 64'd0);
                check("pe_weight_zero", 64'(pe_weight_o), 64'd0);
            end
            check("input_done", 64'(pe_input_done_o), 64'(m > 0 && t == m + 2));
            check("done_timing", 64'(done_o), 64'(t == exp_done_t));
            check("busy", 64'(busy_o), 64'(t != exp_done_t));
            check("pe_en", 64'(pe_en_o), 64'(t != exp_done_t));
            if (done_o) begin
                got = 1'b1;
                check("result", 64'(result_o), 64'(exp_res));
                check("err", 64'(err_o), 64'(exp_err));
            end
        end
        check("done_seen", 64'(got), 64'd1);
        start_i = 1'b0;
        inject_cd = 1'b0;
        @(negedge clk);
        check("done_single_pulse", 64'(done_o), 64'd0);
        check("idle_busy", 64'(busy_o), 64'd0);
        check("result_held", 64'(result_o), 64'(exp_res));
        check("err_held", 64'(err_o), 64'(exp_err));
        last_result = exp_res;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_zero("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("after_reset");

        act_mem[0] = 16'd1; act_mem[1] = 16'd2; act_mem[2] = 16'd3; act_mem[3] = 16'd4;
        wgt_mem[0] = 16'd5; wgt_mem[1] = 16'd6; wgt_mem[2] = 16'd7; wgt_mem[3] = 16'd8;
        pe_lat = 2;
        run_op(4, 1'b0, 1'b0, 1'b0);
        check("len4_result_70", 64'(last_result), 64'd70);

        act_mem[0] = 16'd9; wgt_mem[0] = 16'd3;
        pe_lat = 1;
        run_op(1, 1'b0, 1'b0, 1'b0);
        check("len1_result_27", 64'(last_result), 64'd27);

        run_op(0, 1'b0, 1'b0, 1'b0);

        act_mem[0] = 16'd1; act_mem[1] = 16'd2; act_mem[2] = 16'd3; act_mem[3] = 16'd4;
        wgt_mem[0] = 16'd5; wgt_mem[1] = 16'd6; wgt_mem[2] = 16'd7; wgt_mem[3] = 16'd8;
        pe_lat = 3;
        run_op(4, 1'b0, 1'b1, 1'b0);
        run_op(4, 1'b0, 1'b0, 1'b0);
        check("back_to_back_70", 64'(last_result), 64'd70);

        fill_random();
        run_op(3, 1'b1, 1'b0, 1'b0);
        check("timeout_keeps_result", 64'(last_result), 64'd70);

        fill_random();
        pe_lat = 2;
        run_op(4, 1'b0, 1'b0, 1'b1);

        run_op(7, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 8; r++) begin
            fill_random();
            pe_lat = $urandom_range(1, 5);
            run_op($urandom_range(0, 7), 1'b0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1));
        end

        fill_random();
        start_i = 1'b1;
        len_i = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        check("mid_stream_rd_en", 64'(act_rd_en_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("post_reset_no_done", 64'(done_o), 64'd0);
            check("post_reset_idle", 64'(busy_o), 64'd0);
        end
        last_result = '0;
        pe_lat = 2;
        run_op(2, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
